multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have the port RST, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have the port OpCode, input, 6 bits: instr[31:26] from the instruction register.
REQ-004 The block SHALL have the port Funct, input, 6 bits: instr[5:0].
REQ-005 The block SHALL have the port Zero, input, 1 bit: ALU zero flag.
REQ-006 The block SHALL have the port MemReady, input, 1 bit: unified memory has completed the current access.
REQ-007 The block SHALL have the output ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, Mem2Reg, RegDst, RegWrite, ALUSrcA and ExtOp, 1 bit each: datapath enables and selects.
REQ-008 The block SHALL have the output ports ALUSrcB (2 bits: 0=B, 1=const 4, 2=ext imm, 3=ext imm<<2) and PCSource (2 bits: 0=ALU, 1=ALUOut, 2=jump target).
REQ-009 The block SHALL have the output port ALUOp, 5 bits, using the shared encoding.
REQ-010 The block SHALL have the output ports State (4 bits, current state code), Retire (1 bit, one-cycle pulse per completed instruction) and Halted (1 bit, sticky).

Function
REQ-011 The block SHALL implement a Moore FSM with these state codes: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, RWB=8, BRANCH=9, JUMP=10, TRAP=11.
REQ-012 IDLE SHALL drive all outputs to 0 and go unconditionally to FETCH.
REQ-013 FETCH SHALL assert MemRead, IorD=0, ALUSrcA=0, ALUSrcB=1 and ALUOp=ADD.
REQ-014 In FETCH, IRWrite and PCWrite (PCSource=0) SHALL be asserted only while MemReady=1; FETCH SHALL be held while MemReady=0 and go to DECODE on MemReady=1.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=3, ExtOp=1 and ALUOp=ADD (branch target to ALUOut).
REQ-016 DECODE SHALL branch on OpCode: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> EXEC; addi (001000), ori (001101), lui (001111) -> EXEC; beq (000100) -> BRANCH; j (000010) -> JUMP; any other value -> TRAP.
REQ-017 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=2, ExtOp=1 and ALUOp=ADD, then go to MEMRD (lw) or MEMWR (sw).
REQ-018 MEMRD SHALL assert MemRead with IorD=1, be held until MemReady, then go to MEMWB.
REQ-019 MEMWB SHALL assert RegWrite with Mem2Reg=1 and RegDst=0, then go to FETCH.
REQ-020 MEMWR SHALL assert MemWrite with IorD=1, be held until MemReady, then go to FETCH.
REQ-021 EXEC for R-type SHALL drive ALUSrcA=1, ALUSrcB=0 and ALUOp from Funct: 100001 ADD, 100011 SUB, 100100 AND, 100101 OR, 101010 SLT, 000000 SLL, 000010 SRL.
REQ-022 An unlisted Funct SHALL send EXEC to TRAP.
REQ-023 EXEC for immediate opcodes SHALL drive ALUSrcB=2, with addi -> ADD/ExtOp=1, ori -> OR/ExtOp=0 and lui -> LUI/ExtOp=0.
REQ-024 A non-trapping EXEC SHALL go to RWB.
REQ-025 RWB SHALL assert RegWrite with Mem2Reg=0 and RegDst=1 for R-type or 0 otherwise, then go to FETCH.
REQ-026 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOp=SUB, PCWriteCond=1 and PCSource=1, then go to FETCH; the PC loads only if Zero=1, and that gating is external.
REQ-027 JUMP SHALL assert PCWrite with PCSource=2, then go to FETCH.
REQ-028 Retire SHALL pulse for one cycle on the final cycle of MEMWB, the accepted MEMWR, RWB, BRANCH and JUMP.
REQ-029 TRAP SHALL hold all outputs 0 except Halted=1, and remain in TRAP until RST.
REQ-030 Cycle counts with MemReady tied to 1 SHALL be: lw 5, sw 4, R-type/imm 4, beq 3, j 3.
REQ-031 OpCode and Funct SHALL be sampled only in DECODE and EXEC; changes in other states SHALL have no effect.

Reset
REQ-032 RST=1 SHALL force state to IDLE immediately, regardless of the clock, including mid-wait on MemReady.
REQ-033 While in IDLE after reset, all outputs SHALL be 0, with Halted=0 and Retire=0.
REQ-034 When RST deasserts, the first rising edge SHALL move the FSM to FETCH.

Structure
REQ-035 The state codes, ALUOp codes (ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SRL=6, LUI=7), opcode and funct constants, and ALUSrcB/PCSource encodings SHALL be defined in the shared signal definition package shared with the ALU.
REQ-036 The block SHALL contain one sub-module, alu_op_decode (combinational: OpCode, Funct -> ALUOp, ExtOp, illegal flag); the state register and next-state logic SHALL be in multicycle_ctrl.

Verification
REQ-037 Release reset with MemReady=1 and OpCode=100011 -> State sequence 0,1,2,3,4,5,1; RegWrite=1 and Mem2Reg=1 in state 5; one Retire pulse.
REQ-038 Run sw with MemReady low for 3 cycles in MEMWR -> MemWrite=1 held for 4 cycles; Retire only on the accepting cycle; then FETCH.
REQ-039 Run beq with Zero=1 and then Zero=0 -> both runs show PCWriteCond=1 and PCSource=1 in BRANCH for exactly 1 cycle, and 3 cycles total.
REQ-040 Run R-type with Funct=101010 -> ALUOp=4 in EXEC, RegDst=1 in RWB; Funct=111111 -> TRAP with Halted=1 persisting 20 cycles.
REQ-041 Assert RST mid-FETCH while MemReady=0 -> State=0 with no clock edge, all outputs 0; the FSM resumes FETCH one cycle after release.
REQ-042 Drive OpCode=001111 (lui) -> ExtOp=0, ALUSrcB=2, ALUOp=7 in EXEC; RegDst=0 in RWB.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared signal definitions for the multicycle controller and the ALU.
// Holds state codes, ALUOp codes, opcode/funct constants, the ALUSrcB and
// PCSource select encodings, and the DECODE dispatch helper.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_SLT = 5'd4,
        ALU_SLL = 5'd5,
        ALU_SRL = 5'd6,
        ALU_LUI = 5'd7
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100001;
    localparam logic [5:0] FN_SUB = 6'b100011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // State that DECODE dispatches to for a given opcode.
    function automatic state_t dispatch(input logic [5:0] op);
        state_t s;
        case (op)
            OP_LW, OP_SW:                      s = S_MEMADR;
            OP_RTYPE, OP_ADDI, OP_ORI, OP_LUI: s = S_EXEC;
            OP_BEQ:                            s = S_BRANCH;
            OP_J:                              s = S_JUMP;
            default:                           s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle.
//   master : the controller (reads OpCode/Funct/Zero/MemReady, drives
//            enables, selects, ALUOp, State, Retire, Halted)
//   slave  : the datapath side (mirror directions)
interface multicycle_ctrl_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       Mem2Reg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic       ExtOp;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic [4:0] ALUOp;
    logic [3:0] State;
    logic       Retire;
    logic       Halted;

    modport master (
        input  OpCode, Funct, Zero, MemReady,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               Mem2Reg, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB,
               PCSource, ALUOp, State, Retire, Halted
    );

    modport slave (
        output OpCode, Funct, Zero, MemReady,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               Mem2Reg, RegDst, RegWrite, ALUSrcA, ExtOp, ALUSrcB,
               PCSource, ALUOp, State, Retire, Halted
    );
endinterface

// File: rtl/multicycle_ctrl_alu_op_decode.sv
// Combinational EXEC-stage operation decode.
//   op      : instruction opcode (latched in DECODE)
//   funct   : instruction funct field
//   alu_op  : ALU operation code
//   ext_op  : 1 = sign-extend immediate, 0 = zero-extend
//   illegal : opcode/funct combination not executable in EXEC
module alu_op_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       ext_op,
    output logic       illegal
);
    always_comb begin
        alu_op  = ALU_ADD;
        ext_op  = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  alu_op = ALU_SLL;
                    FN_SRL:  alu_op = ALU_SRL;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                alu_op = ALU_ADD;
                ext_op = 1'b1;
            end
            OP_ORI:  alu_op = ALU_OR;
            OP_LUI:  alu_op = ALU_LUI;
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM.
//   CLK : clock, all state changes on rising edge
//   RST : asynchronous active-high reset to IDLE
//   bus : multicycle_ctrl_if master modport (opcode/funct/status in,
//         datapath enables/selects, ALUOp, State, Retire, Halted out)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    multicycle_ctrl_if.master bus
);
    state_t     state;
    state_t     state_nxt;
    logic [5:0] op_q;
    alu_op_t    dec_alu_op;
    logic       dec_ext_op;
    logic       dec_illegal;

    // Branch PC gating on Zero happens in the datapath, not here.
    logic zero_unused;
    assign zero_unused = bus.Zero;

    alu_op_decode u_alu_op_decode (
        .op      (op_q),
        .funct   (bus.Funct),
        .alu_op  (dec_alu_op),
        .ext_op  (dec_ext_op),
        .illegal (dec_illegal)
    );

    // Opcode is captured in DECODE so later states ignore changes on OpCode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE)
                op_q <= bus.OpCode;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.Mem2Reg     = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ExtOp       = 1'b0;
        bus.ALUSrcB     = '0;
        bus.PCSource    = '0;
        bus.ALUOp       = '0;
        bus.Retire      = 1'b0;
        bus.Halted      = 1'b0;
        bus.State       = state;

        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = SRCB_FOUR;
                bus.ALUOp   = ALU_ADD;
                if (bus.MemReady) begin
                    bus.IRWrite  = 1'b1;
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = PCSRC_ALU;
                    state_nxt    = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.ALUSrcB = SRCB_IMM_SH;
                bus.ExtOp   = 1'b1;
                bus.ALUOp   = ALU_ADD;
                state_nxt   = dispatch(bus.OpCode);
            end
            S_MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = SRCB_IMM;
                bus.ExtOp   = 1'b1;
                bus.ALUOp   = ALU_ADD;
                state_nxt   = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.MemReady)
                    state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = 1'b1;
                bus.Retire   = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_MEMWR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.MemReady) begin
                    bus.Retire = 1'b1;
                    state_nxt  = S_FETCH;
                end
            end
            S_EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = (op_q == OP_RTYPE) ? SRCB_B : SRCB_IMM;
                bus.ALUOp   = dec_alu_op;
                bus.ExtOp   = dec_ext_op;
                state_nxt   = dec_illegal ? S_TRAP : S_RWB;
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = (op_q == OP_RTYPE);
                bus.Retire   = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUSrcB     = SRCB_B;
                bus.ALUOp       = ALU_SUB;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = PCSRC_ALUOUT;
                bus.Retire      = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = PCSRC_JUMP;
                bus.Retire   = 1'b1;
                state_nxt    = S_FETCH;
            end
            S_TRAP: bus.Halted = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl. Each cycle's expected
// {State, outputs} is queued as the stimulus is applied and popped when the
// DUT outputs are sampled (1 time unit after the falling edge).
module tb_multicycle_ctrl;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_MEMADR = 4'd3;
    localparam logic [3:0] ST_MEMRD  = 4'd4;
    localparam logic [3:0] ST_MEMWB  = 4'd5;
    localparam logic [3:0] ST_MEMWR  = 4'd6;
    localparam logic [3:0] ST_EXEC   = 4'd7;
    localparam logic [3:0] ST_RWB    = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_JUMP   = 4'd10;
    localparam logic [3:0] ST_TRAP   = 4'd11;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       Mem2Reg;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrcA;
        logic       ExtOp;
        logic [1:0] ALUSrcB;
        logic [1:0] PCSource;
        logic [4:0] ALUOp;
        logic       Retire;
        logic       Halted;
    } outs_t;

    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;
    logic [25:0] exp_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Expected output patterns per state.
    function automatic outs_t o_none();
        outs_t o = '0;
        return o;
    endfunction
    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.MemRead = 1'b1; o.ALUSrcB = 2'd1;
        o.IRWrite = rdy;  o.PCWrite = rdy;
        return o;
    endfunction
    function automatic outs_t o_decode();
        outs_t o = '0;
        o.ALUSrcB = 2'd3; o.ExtOp = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memadr();
        outs_t o = '0;
        o.ALUSrcA = 1'b1; o.ALUSrcB = 2'd2; o.ExtOp = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memrd();
        outs_t o = '0;
        o.MemRead = 1'b1; o.IorD = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memwb();
        outs_t o = '0;
        o.RegWrite = 1'b1; o.Mem2Reg = 1'b1; o.Retire = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_memwr(input logic rdy);
        outs_t o = '0;
        o.MemWrite = 1'b1; o.IorD = 1'b1; o.Retire = rdy;
        return o;
    endfunction
    function automatic outs_t o_exec(input logic [1:0] srcb, input logic [4:0] aluop,
                                     input logic ext);
        outs_t o = '0;
        o.ALUSrcA = 1'b1; o.ALUSrcB = srcb; o.ALUOp = aluop; o.ExtOp = ext;
        return o;
    endfunction
    function automatic outs_t o_rwb(input logic regdst);
        outs_t o = '0;
        o.RegWrite = 1'b1; o.RegDst = regdst; o.Retire = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_branch();
        outs_t o = '0;
        o.ALUSrcA = 1'b1; o.ALUOp = 5'd1; o.PCWriteCond = 1'b1;
        o.PCSource = 2'd1; o.Retire = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_jump();
        outs_t o = '0;
        o.PCWrite = 1'b1; o.PCSource = 2'd2; o.Retire = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_trap();
        outs_t o = '0;
        o.Halted = 1'b1;
        return o;
    endfunction

    function automatic outs_t observed();
        outs_t r;
        r = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
             bus.IRWrite, bus.Mem2Reg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
             bus.ExtOp, bus.ALUSrcB, bus.PCSource, bus.ALUOp, bus.Retire,
             bus.Halted};
        return r;
    endfunction

    task automatic check_now(input string tag);
        logic [25:0] e;
        logic [25:0] a;
        e = exp_q.pop_front();
        a = {bus.State, observed()};
        checks++;
        assert (a === e) else begin
            errors++;
            $error("FAIL %s: observed state/outs %h, expected %h", tag, a, e);
        end
    endtask

    // One cycle: queue expectation, sample, advance to next falling edge.
    task automatic cyc(input string tag, input logic [3:0] st, input outs_t o);
        exp_q.push_back({st, o});
        #1;
        check_now(tag);
        @(negedge CLK);
    endtask

    task automatic cyc_state(input string tag, input logic [3:0] st);
        checks++;
        #1;
        assert (bus.State === st) else begin
            errors++;
            $error("FAIL %s: observed state %0d, expected %0d", tag, bus.State, st);
        end
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        bus.MemReady = 1'b1;
        bus.OpCode   = 6'b100011;
        bus.Funct    = 6'b000000;
        bus.Zero     = 1'b0;
        @(negedge CLK);
        cyc("reset_idle", ST_IDLE, o_none());
        RST = 1'b0;
        cyc("idle_release", ST_IDLE, o_none());

        // lw; OpCode changed after DECODE must not redirect to MEMWR
        cyc("lw_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("lw_decode", ST_DECODE, o_decode());
        bus.OpCode = 6'b101011;
        cyc("lw_memadr", ST_MEMADR, o_memadr());
        cyc("lw_memrd", ST_MEMRD, o_memrd());
        cyc("lw_memwb", ST_MEMWB, o_memwb());

        // sw with three wait cycles
        cyc("sw_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("sw_decode", ST_DECODE, o_decode());
        cyc("sw_memadr", ST_MEMADR, o_memadr());
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", ST_MEMWR, o_memwr(1'b0));
        bus.MemReady = 1'b1;
        cyc("sw_memwr_accept", ST_MEMWR, o_memwr(1'b1));

        // beq Zero=1 with a stalled fetch, then beq Zero=0
        bus.OpCode = 6'b000100;
        bus.Zero = 1'b1;
        bus.MemReady = 1'b0;
        cyc("beq_fetch_wait", ST_FETCH, o_fetch(1'b0));
        bus.MemReady = 1'b1;
        cyc("beq1_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("beq1_decode", ST_DECODE, o_decode());
        cyc("beq1_branch", ST_BRANCH, o_branch());
        bus.Zero = 1'b0;
        cyc("beq0_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("beq0_decode", ST_DECODE, o_decode());
        cyc("beq0_branch", ST_BRANCH, o_branch());

        // j
        bus.OpCode = 6'b000010;
        cyc("j_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("j_decode", ST_DECODE, o_decode());
        cyc("j_jump", ST_JUMP, o_jump());

        // R-type slt
        bus.OpCode = 6'b000000;
        bus.Funct  = 6'b101010;
        cyc("slt_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("slt_decode", ST_DECODE, o_decode());
        cyc("slt_exec", ST_EXEC, o_exec(2'd0, 5'd4, 1'b0));
        cyc("slt_rwb", ST_RWB, o_rwb(1'b1));

        // lui
        bus.OpCode = 6'b001111;
        cyc("lui_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("lui_decode", ST_DECODE, o_decode());
        cyc("lui_exec", ST_EXEC, o_exec(2'd2, 5'd7, 1'b0));
        cyc("lui_rwb", ST_RWB, o_rwb(1'b0));

        // addi
        bus.OpCode = 6'b001000;
        cyc("addi_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("addi_decode", ST_DECODE, o_decode());
        cyc("addi_exec", ST_EXEC, o_exec(2'd2, 5'd0, 1'b1));
        cyc("addi_rwb", ST_RWB, o_rwb(1'b0));

        // asynchronous reset while FETCH waits on memory
        bus.MemReady = 1'b0;
        cyc("fetch_wait2", ST_FETCH, o_fetch(1'b0));
        #2;
        RST = 1'b1;
        exp_q.push_back({ST_IDLE, o_none()});
        #1;
        check_now("async_reset");
        @(negedge CLK);
        RST = 1'b0;
        cyc("idle_after_async", ST_IDLE, o_none());
        cyc("fetch_resume", ST_FETCH, o_fetch(1'b0));

        // illegal funct -> TRAP, sticky for 20 cycles despite input changes
        bus.MemReady = 1'b1;
        bus.OpCode = 6'b000000;
        bus.Funct  = 6'b111111;
        cyc("ill_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("ill_decode", ST_DECODE, o_decode());
        cyc_state("ill_exec", ST_EXEC);
        bus.OpCode = 6'b100011;
        bus.Funct  = 6'b100001;
        for (int i = 0; i < 20; i++) cyc("trap_hold", ST_TRAP, o_trap());

        // reset out of TRAP, then illegal opcode -> TRAP from DECODE
        RST = 1'b1;
        cyc("reset_from_trap", ST_IDLE, o_none());
        RST = 1'b0;
        cyc("idle_after_trap", ST_IDLE, o_none());
        bus.OpCode = 6'b111111;
        cyc("badop_fetch", ST_FETCH, o_fetch(1'b1));
        cyc("badop_decode", ST_DECODE, o_decode());
        cyc("badop_trap", ST_TRAP, o_trap());
        cyc("badop_trap2", ST_TRAP, o_trap());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
